array_sweep_writer: RTL and testbench

- Parametrised successor of the 8-bit indexed array writer.
- A sequencer walks an index counter across an output array of NUM_ELEM elements. Each enabled cycle, it writes a captured data word into the element the index selects.
- Adds parametrised element width and depth, a registered capture stage (no latches), one-shot and continuous sweep modes, and a start/busy/done handshake with abort.
- Sits between control logic and downstream consumers that read the whole array in parallel.

---
 rtl/array_sweep_writer.sv | 124 ++++++++++++
 tb/tb_array_sweep_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_sweep_writer.sv
// rtl/array_sweep_writer.sv - indexed array sweep writer with one-shot/continuous modes
module array_sweep_writer #(
    parameter int WIDTH    = 1,
    parameter int NUM_ELEM = 8,
    parameter int IDX_W    = $clog2(NUM_ELEM)
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic                      i_en,
    input  logic                      i_mode,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic                      i_load,
    input  logic [WIDTH-1:0]          i_d,
    output logic [NUM_ELEM*WIDTH-1:0] o_a,
    output logic [IDX_W-1:0]          o_idx,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_wrap
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Last valid index; the wrap is an explicit compare so odd depths work.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    state_t           state;
    state_t           state_nxt;
    logic             mode_q;
    logic             mode_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             done_nxt;
    logic             wrap_nxt;
    logic             wr_en;
    logic [WIDTH-1:0] hold;

    // Next-state, index advance and write strobe for the sweep sequencer
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        idx_nxt   = o_idx;
        done_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        wr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    state_nxt = ST_SWEEP;
                    idx_nxt   = '0;
                    mode_nxt  = i_mode;
                end
            end
            ST_SWEEP: begin
                if (i_abort) begin
                    // Abort wins over enable; array keeps what was written so far.
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end else if (i_en) begin
                    wr_en = 1'b1;
                    if (o_idx == LAST_IDX) begin
                        idx_nxt = '0;
                        if (mode_q) begin
                            wrap_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        idx_nxt = o_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Sequencer state, latched mode, index and event pulses
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state  <= ST_IDLE;
            mode_q <= 1'b0;
            o_idx  <= '0;
            o_done <= 1'b0;
            o_wrap <= 1'b0;
        end else begin
            state  <= state_nxt;
            mode_q <= mode_nxt;
            o_idx  <= idx_nxt;
            o_done <= done_nxt;
            o_wrap <= wrap_nxt;
        end
    end

    // Hold register; a write on the same edge still sees the previous value
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            hold <= '0;
        end else if (i_load) begin
            hold <= i_d;
        end
    end

    // Scatter the hold word into the element selected by the index
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            o_a <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_ELEM; k++) begin
                if (o_idx == IDX_W'(k)) begin
                    o_a[k*WIDTH +: WIDTH] <= hold;
                end
            end
        end
    end

    assign o_busy = (state == ST_SWEEP);

endmodule

// File: tb/tb_array_sweep_writer.sv
// tb/tb_array_sweep_writer.sv - self-checking bench for array_sweep_writer
module tb_array_sweep_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    [2];
    logic        mode  [2];
    logic        start [2];
    logic        abort [2];
    logic        load  [2];
    logic [3:0]  d     [2];

    logic [7:0]  a0;
    logic [19:0] a1;
    logic [2:0]  idx0, idx1;
    logic        busy0, busy1, done0, done1, wrap0, wrap1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: instance 0 is WIDTH=1/NUM_ELEM=8, instance 1 is WIDTH=4/NUM_ELEM=5
    int m_a    [2][8];
    int m_idx  [2];
    int m_busy [2];
    int m_mode [2];
    int m_hold [2];
    int m_done [2];
    int m_wrap [2];

    always #5 clk = ~clk;

    array_sweep_writer #(.WIDTH(1), .NUM_ELEM(8)) u0 (
        .i_clk(clk), .i_arst(rst_n), .i_en(en[0]), .i_mode(mode[0]),
        .i_start(start[0]), .i_abort(abort[0]), .i_load(load[0]), .i_d(d[0][0:0]),
        .o_a(a0), .o_idx(idx0), .o_busy(busy0), .o_done(done0), .o_wrap(wrap0)
    );

    array_sweep_writer #(.WIDTH(4), .NUM_ELEM(5)) u1 (
        .i_clk(clk), .i_arst(rst_n), .i_en(en[1]), .i_mode(mode[1]),
        .i_start(start[1]), .i_abort(abort[1]), .i_load(load[1]), .i_d(d[1]),
        .o_a(a1), .o_idx(idx1), .o_busy(busy1), .o_done(done1), .o_wrap(wrap1)
    );

    function automatic int n_of(int i);
        return (i == 0) ? 8 : 5;
    endfunction

    function automatic int w_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] model_array(int i);
        logic [31:0] r = '0;
        int mask = (1 << w_of(i)) - 1;
        for (int k = 0; k < n_of(i); k++)
            r = r | (32'(m_a[i][k] & mask) << (k * w_of(i)));
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference behaviour: one step per rising edge, straight from the sweep rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 8; k++) m_a[i][k] = 0;
                m_idx[i] = 0; m_busy[i] = 0; m_mode[i] = 0;
                m_hold[i] = 0; m_done[i] = 0; m_wrap[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int new_hold;
                new_hold = m_hold[i];
                m_done[i] = 0;
                m_wrap[i] = 0;
                if (load[i]) new_hold = int'(d[i]) & ((1 << w_of(i)) - 1);
                if (m_busy[i] == 0) begin
                    if (start[i] && !abort[i]) begin
                        m_busy[i] = 1;
                        m_idx[i]  = 0;
                        m_mode[i] = int'(mode[i]);
                    end
                end else if (abort[i]) begin
                    m_busy[i] = 0;
                    m_idx[i]  = 0;
                end else if (en[i]) begin
                    m_a[i][m_idx[i]] = m_hold[i];
                    if (m_idx[i] == n_of(i) - 1) begin
                        m_idx[i] = 0;
                        if (m_mode[i] != 0) m_wrap[i] = 1;
                        else begin
                            m_busy[i] = 0;
                            m_done[i] = 1;
                        end
                    end else begin
                        m_idx[i] = m_idx[i] + 1;
                    end
                end
                m_hold[i] = new_hold;
            end
        end
    end

    // Every-cycle comparison of both instances against the model, mid-cycle
    always @(negedge clk) begin
        chk("m_a0",    32'(a0),    model_array(0));
        chk("m_idx0",  32'(idx0),  32'(m_idx[0]));
        chk("m_busy0", 32'(busy0), 32'(m_busy[0]));
        chk("m_done0", 32'(done0), 32'(m_done[0]));
        chk("m_wrap0", 32'(wrap0), 32'(m_wrap[0]));
        chk("m_a1",    32'(a1),    model_array(1));
        chk("m_idx1",  32'(idx1),  32'(m_idx[1]));
        chk("m_busy1", 32'(busy1), 32'(m_busy[1]));
        chk("m_done1", 32'(done1), 32'(m_done[1]));
        chk("m_wrap1", 32'(wrap1), 32'(m_wrap[1]));
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i] = 0; mode[i] = 0; start[i] = 0; abort[i] = 0; load[i] = 0; d[i] = '0;
        end
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_a0", 32'(a0), 32'h0);
        chk("rst_idx0", 32'(idx0), 32'h0);
        chk("rst_busy0", 32'(busy0), 32'h0);
        chk("rst_a1", 32'(a1), 32'h0);

        // One-shot fill of the 8x1 array with ones
        load[0] = 1; d[0] = 4'h1; tick();
        load[0] = 0; start[0] = 1; mode[0] = 0; en[0] = 1; tick();
        start[0] = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("fill_a", 32'(a0), (32'h1 << k) - 1);
            if (k < 8) begin
                chk("fill_busy", 32'(busy0), 32'h1);
                chk("fill_nodone", 32'(done0), 32'h0);
            end
        end
        chk("fill_done", 32'(done0), 32'h1);
        chk("fill_busy_fall", 32'(busy0), 32'h0);
        chk("fill_idx", 32'(idx0), 32'h0);

        // Back-to-back start in the done cycle, now writing zeros
        start[0] = 1; load[0] = 1; d[0] = 4'h0; tick();
        start[0] = 0; load[0] = 0;
        chk("b2b_busy", 32'(busy0), 32'h1);
        chk("b2b_done_once", 32'(done0), 32'h0);
        tick();
        chk("b2b_a", 32'(a0), 32'hFE);
        start[0] = 1; tick();
        start[0] = 0;
        chk("start_ignored_idx", 32'(idx0), 32'h2);
        tick();
        chk("pre_abort_a", 32'(a0), 32'hF8);
        chk("pre_abort_idx", 32'(idx0), 32'h3);
        abort[0] = 1; tick();
        abort[0] = 0;
        chk("abort_busy", 32'(busy0), 32'h0);
        chk("abort_idx", 32'(idx0), 32'h0);
        chk("abort_done", 32'(done0), 32'h0);
        chk("abort_a", 32'(a0), 32'hF8);

        // Pause and same-cycle load on the 5x4 array
        load[1] = 1; d[1] = 4'hA; tick();
        load[1] = 0; start[1] = 1; mode[1] = 0; en[1] = 1; tick();
        start[1] = 0;
        repeat (2) tick();
        chk("pause_pre_idx", 32'(idx1), 32'h2);
        en[1] = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pause_idx", 32'(idx1), 32'h2);
            chk("pause_a", 32'(a1), 32'h000AA);
        end
        en[1] = 1; load[1] = 1; d[1] = 4'h5; tick();
        load[1] = 0;
        chk("resume_old_hold", 32'(a1), 32'h00AAA);
        chk("resume_idx", 32'(idx1), 32'h3);
        tick();
        chk("new_hold_e3", 32'(a1), 32'h05AAA);
        tick();
        chk("new_hold_e4", 32'(a1), 32'h55AAA);
        chk("pause_done", 32'(done1), 32'h1);
        chk("pause_busy_fall", 32'(busy1), 32'h0);

        // Continuous sweep, mode input flipped mid-sweep has no effect
        mode[1] = 1; start[1] = 1; tick();
        start[1] = 0; mode[1] = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("cont_idx", 32'(idx1), 32'(k % 5));
            chk("cont_wrap", 32'(wrap1), (k % 5 == 0) ? 32'h1 : 32'h0);
            chk("cont_nodone", 32'(done1), 32'h0);
            chk("cont_busy", 32'(busy1), 32'h1);
        end
        abort[1] = 1; tick();
        abort[1] = 0;
        chk("cont_abort_busy", 32'(busy1), 32'h0);

        // Asynchronous reset in the middle of a sweep
        start[0] = 1; mode[0] = 0; en[0] = 1; tick();
        start[0] = 0;
        repeat (2) tick();
        chk("pre_rst_busy", 32'(busy0), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_a0", 32'(a0), 32'h0);
        chk("arst_idx0", 32'(idx0), 32'h0);
        chk("arst_busy0", 32'(busy0), 32'h0);
        chk("arst_a1", 32'(a1), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_idle", 32'(busy0), 32'h0);
            chk("post_rst_a", 32'(a0), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
